// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - IFU/LSU arbiter sharing one memory port, one transaction at a time
// Round-robin or fixed-LSU-priority grant; the response wait is guarded by a saturating timeout.
module mem_arbiter #(
  parameter int PRIORITY = 0,
  parameter int TIMEOUT  = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ifu_reqValid,
  input  logic [31:0] ifu_addr,
  output logic        ifu_respValid,
  output logic [31:0] ifu_rdata,
  output logic        ifu_err,
  input  logic        lsu_reqValid,
  input  logic [31:0] lsu_addr,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wmask,
  output logic        lsu_respValid,
  output logic [31:0] lsu_rdata,
  output logic        lsu_err,
  output logic        mem_reqValid,
  input  logic        mem_reqReady,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_respValid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_err,
  output logic        busy
);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} state_t;

  state_t        state;
  logic          last_lsu;
  logic          grant_lsu;
  logic [CW-1:0] cnt;

  logic          ifu_cand;
  logic          lsu_cand;
  logic          pick_lsu;
  logic [CW:0]   cnt_inc;
  logic          expired;
  logic          finish;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;

  // A requester still showing its response pulse is finishing, not asking again.
  assign ifu_cand = ifu_reqValid && !ifu_respValid;
  assign lsu_cand = lsu_reqValid && !lsu_respValid;
  assign pick_lsu = lsu_cand && (!ifu_cand || (PRIORITY != 0) || !last_lsu);

  assign cnt_inc = {1'b0, cnt} + (CW + 1)'(1);
  assign expired = (TIMEOUT != 0) && (int'(cnt_inc) == TIMEOUT);
  assign finish  = mem_respValid || expired;

  // A real response takes precedence over a timeout landing in the same cycle.
  assign rsp_rdata = mem_respValid ? mem_rdata : 32'h0;
  assign rsp_err   = mem_respValid ? mem_err   : 1'b1;

  assign busy = (state != IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      last_lsu      <= 1'b0;
      grant_lsu     <= 1'b0;
      cnt           <= '0;
      mem_reqValid  <= 1'b0;
      mem_addr      <= 32'h0;
      mem_wen       <= 1'b0;
      mem_wdata     <= 32'h0;
      mem_wmask     <= 4'h0;
      ifu_respValid <= 1'b0;
      ifu_rdata     <= 32'h0;
      ifu_err       <= 1'b0;
      lsu_respValid <= 1'b0;
      lsu_rdata     <= 32'h0;
      lsu_err       <= 1'b0;
    end else begin
      ifu_respValid <= 1'b0;
      lsu_respValid <= 1'b0;
      case (state)
        IDLE: begin
          if (ifu_cand || lsu_cand) begin
            grant_lsu    <= pick_lsu;
            last_lsu     <= pick_lsu;
            mem_reqValid <= 1'b1;
            state        <= ISSUE;
            if (pick_lsu) begin
              mem_addr  <= lsu_addr;
              mem_wen   <= lsu_wen;
              mem_wdata <= lsu_wdata;
              mem_wmask <= lsu_wen ? lsu_wmask : 4'h0;
            end else begin
              mem_addr  <= ifu_addr;
              mem_wen   <= 1'b0;
              mem_wdata <= 32'h0;
              mem_wmask <= 4'h0;
            end
          end
        end
        ISSUE: begin
          if (mem_reqReady) begin
            mem_reqValid <= 1'b0;
            cnt          <= '0;
            state        <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != '1) cnt <= cnt + CW'(1);
          if (finish) begin
            state <= mem_respValid ? IDLE : DRAIN;
            if (grant_lsu) begin
              lsu_respValid <= 1'b1;
              lsu_rdata     <= rsp_rdata;
              lsu_err       <= rsp_err;
            end else begin
              ifu_respValid <= 1'b1;
              ifu_rdata     <= rsp_rdata;
              ifu_err       <= rsp_err;
            end
          end
        end
        DRAIN: begin
          if (mem_respValid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a randomized memory/requester model
module tb_mem_arbiter;
  localparam int PRI = 0;
  localparam int TO  = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ifu_reqValid, ifu_respValid, ifu_err;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_reqValid, lsu_wen, lsu_respValid, lsu_err;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wmask;
  logic        mem_reqValid, mem_reqReady, mem_wen, mem_respValid, mem_err, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  always #5 clock = ~clock;

  mem_arbiter #(.PRIORITY(PRI), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .ifu_reqValid(ifu_reqValid), .ifu_addr(ifu_addr), .ifu_respValid(ifu_respValid),
    .ifu_rdata(ifu_rdata), .ifu_err(ifu_err),
    .lsu_reqValid(lsu_reqValid), .lsu_addr(lsu_addr), .lsu_wen(lsu_wen),
    .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask), .lsu_respValid(lsu_respValid),
    .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
    .mem_reqValid(mem_reqValid), .mem_reqReady(mem_reqReady), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_respValid(mem_respValid), .mem_rdata(mem_rdata), .mem_err(mem_err),
    .busy(busy)
  );

  int checks = 0;
  int failures = 0;

  logic [32:0] q_ifu[$];
  logic [32:0] q_lsu[$];
  logic        grant_log[$];
  logic        m_last_lsu = 1'b0, owner_lsu = 1'b0, exp_lsu;
  logic [31:0] e_addr, e_wdata;
  logic        e_wen, e_chk_wdata;
  logic [3:0]  e_wmask;
  logic [32:0] hold_ifu = '0, hold_lsu = '0, popped;
  logic        prev_mrv = 1'b0, prev_ei = 1'b0, prev_el = 1'b0;
  int          mrv_len = 0, last_mrv_len = 0, resp_pulses = 0;

  logic        dir_en = 1'b1, dir_e = 1'b0;
  int          dir_d = 1, dir_stall = 0;
  logic [31:0] dir_r = 32'h0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string name);
    check({name, "_ctrl"}, 64'({mem_reqValid, mem_wen, busy, ifu_respValid, ifu_err,
                                lsu_respValid, lsu_err, mem_wmask}), 64'd0);
    check({name, "_buses"}, 64'(mem_addr | mem_wdata | ifu_rdata | lsu_rdata), 64'd0);
  endtask

  // Monitor: arbitration model at each grant, field stability, response scoreboard.
  always @(negedge clock) begin
    if (!reset) begin
      q_ifu.delete(); q_lsu.delete();
      m_last_lsu = 1'b0; hold_ifu = '0; hold_lsu = '0;
      prev_mrv = 1'b0; prev_ei = 1'b0; prev_el = 1'b0; mrv_len = 0;
    end else begin
      if (mem_reqValid && !prev_mrv) begin
        check("grant_has_requester", 64'(prev_ei | prev_el), 64'd1);
        exp_lsu     = prev_el && (!prev_ei || (PRI != 0) || !m_last_lsu);
        m_last_lsu  = exp_lsu;
        owner_lsu   = exp_lsu;
        e_addr      = exp_lsu ? lsu_addr : ifu_addr;
        e_wen       = exp_lsu ? lsu_wen : 1'b0;
        e_wmask     = (exp_lsu && lsu_wen) ? lsu_wmask : 4'h0;
        e_wdata     = lsu_wdata;
        e_chk_wdata = exp_lsu && lsu_wen;
        grant_log.push_back(mem_addr[29]);
      end
      if (mem_reqValid) begin
        check("mem_fields", 64'({mem_addr, mem_wen, mem_wmask}), 64'({e_addr, e_wen, e_wmask}));
        if (e_chk_wdata) check("mem_wdata", 64'(mem_wdata), 64'(e_wdata));
        mrv_len++;
      end else if (prev_mrv) begin
        last_mrv_len = mrv_len;
        mrv_len = 0;
      end
      if (ifu_respValid) begin
        resp_pulses++;
        if (q_ifu.size() == 0) begin
          checks++; failures++;
          $display("FAIL ifu_resp_unexpected actual=pulse required=no_pulse");
        end else begin
          popped = q_ifu.pop_front();
          check("ifu_resp", 64'({ifu_err, ifu_rdata}), 64'(popped));
          hold_ifu = popped;
        end
      end else check("ifu_hold", 64'({ifu_err, ifu_rdata}), 64'(hold_ifu));
      if (lsu_respValid) begin
        resp_pulses++;
        if (q_lsu.size() == 0) begin
          checks++; failures++;
          $display("FAIL lsu_resp_unexpected actual=pulse required=no_pulse");
        end else begin
          popped = q_lsu.pop_front();
          check("lsu_resp", 64'({lsu_err, lsu_rdata}), 64'(popped));
          hold_lsu = popped;
        end
      end else check("lsu_hold", 64'({lsu_err, lsu_rdata}), 64'(hold_lsu));
      prev_mrv = mem_reqValid;
      prev_ei  = ifu_reqValid && !ifu_respValid;
      prev_el  = lsu_reqValid && !lsu_respValid;
    end
  end

  // Memory model: stalls acceptance, answers d cycles after accept, pushes expected response.
  initial begin
    int cd, stall, d;
    logic iss, acc, e, re;
    logic [31:0] r, rr;
    cd = 0; stall = 0; iss = 1'b0; acc = 1'b0; re = 1'b0; rr = '0;
    mem_reqReady = 1'b0; mem_respValid = 1'b0; mem_rdata = '0; mem_err = 1'b0;
    forever begin
      @(posedge clock); #1;
      mem_respValid = 1'b0;
      mem_rdata = $urandom;
      mem_err = 1'($urandom_range(0, 1));
      if (acc) begin
        if (dir_en) begin d = dir_d; r = dir_r; e = dir_e; end
        else begin d = $urandom_range(1, TO + 3); r = $urandom; e = ($urandom_range(0, 3) == 0); end
        cd = d; rr = r; re = e;
        if (owner_lsu) q_lsu.push_back((d <= TO) ? {e, r} : {1'b1, 32'h0});
        else           q_ifu.push_back((d <= TO) ? {e, r} : {1'b1, 32'h0});
      end
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin mem_respValid = 1'b1; mem_rdata = rr; mem_err = re; end
      end
      if (mem_reqValid && !iss) begin
        iss = 1'b1;
        stall = dir_en ? dir_stall : $urandom_range(0, 3);
      end
      if (!mem_reqValid) iss = 1'b0;
      if (stall > 0) begin mem_reqReady = 1'b0; stall--; end
      else mem_reqReady = 1'b1;
      @(negedge clock);
      acc = reset && mem_reqValid && mem_reqReady;
    end
  end

  task automatic do_ifu(input logic [31:0] a, output int lat);
    int n;
    ifu_addr = a; ifu_reqValid = 1'b1; n = 0; lat = -1;
    while (n < 300 && lat < 0) begin
      @(negedge clock); n++;
      if (ifu_respValid) lat = n - 1;
    end
    if (lat < 0) begin
      checks++; failures++;
      $display("FAIL ifu_wait actual=no_response required=response_within_300");
    end
    @(posedge clock); #1;
    ifu_reqValid = 1'b0;
  endtask

  task automatic do_lsu(input logic [31:0] a, input logic w, input logic [31:0] wd,
                        input logic [3:0] wm, output int lat);
    int n;
    lsu_addr = a; lsu_wen = w; lsu_wdata = wd; lsu_wmask = wm;
    lsu_reqValid = 1'b1; n = 0; lat = -1;
    while (n < 300 && lat < 0) begin
      @(negedge clock); n++;
      if (lsu_respValid) lat = n - 1;
    end
    if (lat < 0) begin
      checks++; failures++;
      $display("FAIL lsu_wait actual=no_response required=response_within_300");
    end
    @(posedge clock); #1;
    lsu_reqValid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, m, pulses0;
    ifu_reqValid = 1'b0; ifu_addr = '0;
    lsu_reqValid = 1'b0; lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
    #1 check_zero("reset_t0");
    repeat (2) @(negedge clock);
    check_zero("reset_held");
    @(posedge clock); #1 reset = 1'b1;

    // Both requesting continuously, zero-wait memory: LSU first, then alternating.
    dir_en = 1'b1; dir_d = 1; dir_stall = 0; dir_r = 32'h1234_5678; dir_e = 1'b0;
    grant_log.delete();
    fork
      begin : alt_ifu
        int l;
        repeat (2) do_ifu(32'h3000_0100, l);
      end
      begin : alt_lsu
        int l;
        repeat (2) do_lsu(32'h1000_0200, 1'b0, 32'h0, 4'h0, l);
      end
    join
    check("alt_count", 64'(grant_log.size()), 64'd4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      check($sformatf("alt_grant%0d_is_ifu", i), 64'(grant_log[i]), 64'(i % 2));

    // Single fetch latency.
    repeat (2) @(posedge clock); #1;
    dir_r = 32'h0000_0413;
    do_ifu(32'h3000_0000, lat);
    check("ifu_fetch_latency", 64'(lat), 64'd3);

    // Store with four stall cycles.
    dir_stall = 4; dir_r = 32'h0;
    do_lsu(32'h1000_0000, 1'b1, 32'h41, 4'h1, lat);
    check("store_latency", 64'(lat), 64'd7);
    check("store_reqvalid_len", 64'(last_mrv_len), 64'd5);
    dir_stall = 0;

    // Silent memory: timeout error, late response drained.
    dir_d = TO + 20; dir_r = 32'hDEAD_BEEF; dir_e = 1'b0;
    do_lsu(32'h1000_0040, 1'b0, 32'h0, 4'h0, lat);
    check("timeout_latency", 64'(lat), 64'(2 + TO));
    @(negedge clock);
    check("busy_in_drain", 64'(busy), 64'd1);
    m = 1;
    while (busy && m < 60) begin @(negedge clock); m++; end
    check("drain_cycles", 64'(m), 64'd20);
    @(posedge clock); #1;
    dir_d = 1; dir_r = 32'h0000_0013;
    do_ifu(32'h3000_0004, lat);
    check("post_drain_fetch_latency", 64'(lat), 64'd3);

    // Load with memory error; IFU response registers must not move.
    dir_d = 2; dir_r = 32'h0000_CAFE; dir_e = 1'b1;
    do_lsu(32'h1000_0080, 1'b0, 32'h0, 4'h0, lat);
    check("err_load_latency", 64'(lat), 64'd4);
    dir_e = 1'b0;

    // Reset in WAIT, then a stray response after release.
    dir_d = 6;
    lsu_addr = 32'h1000_00C0; lsu_wen = 1'b0; lsu_reqValid = 1'b1;
    repeat (3) @(posedge clock);
    #2;
    check("busy_before_reset", 64'(busy), 64'd1);
    reset = 1'b0;
    #1 check_zero("reset_in_wait");
    lsu_reqValid = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1 reset = 1'b1;
    pulses0 = resp_pulses;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("idle_after_reset", 64'(busy), 64'd0);
    end
    check("stray_resp_ignored", 64'(resp_pulses), 64'(pulses0));
    @(posedge clock); #1;

    // Randomized traffic against the arbitration/response model.
    dir_en = 1'b0;
    fork
      begin : rnd_ifu
        int l, g;
        repeat (30) begin
          g = $urandom_range(0, 3);
          repeat (g) begin @(posedge clock); #1; end
          do_ifu({4'h3, 28'($urandom)}, l);
        end
      end
      begin : rnd_lsu
        int l, g;
        logic w;
        repeat (30) begin
          g = $urandom_range(0, 3);
          repeat (g) begin @(posedge clock); #1; end
          w = 1'($urandom_range(0, 1));
          do_lsu({4'h1, 28'($urandom)}, w, $urandom, 4'($urandom_range(0, 15)), l);
        end
      end
    join
    repeat (30) @(negedge clock);
    check("ifu_queue_empty", 64'(q_ifu.size()), 64'd0);
    check("lsu_queue_empty", 64'(q_lsu.size()), 64'd0);
    check("idle_at_end", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
